// File: rtl/scaler_bank_if.sv
// Scaler bank bus bundle: counter inputs, period flag and byte-wide read port.
interface scaler_bank_if #(
  parameter int NUM_CH   = 32,
  parameter int ADR_BITS = 8
);
  logic [NUM_CH-1:0]   scal_i;
  logic                pps_i;
  logic                rd_i;
  logic [ADR_BITS-1:0] adr_i;
  logic [7:0]          dat_o;
  logic                valid_o;
  logic                update_o;
  logic                timeout_o;

  modport master (
    output scal_i, pps_i, rd_i, adr_i,
    input  dat_o, valid_o, update_o, timeout_o
  );

  modport slave (
    input  scal_i, pps_i, rd_i, adr_i,
    output dat_o, valid_o, update_o, timeout_o
  );
endinterface

// File: rtl/scaler_bank.sv
// Bank of NUM_CH saturating event scalers latched per PPS period (or timeout), read as bytes.
// Read data 1 cycle after rd_i, one byte per cycle, no backpressure; update_o 1 cycle after period end.
module scaler_bank #(
  parameter int NUM_CH        = 32,
  parameter int PRESCALE_BITS = 5,
  parameter int OUTPUT_BITS   = 16,
  parameter int EDGE_MODE     = 1,
  parameter int PPS_TIMEOUT   = 0,
  parameter int ADR_BITS      = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  scaler_bank_if.slave bus
);
  localparam int CW        = PRESCALE_BITS + OUTPUT_BITS;
  localparam int BYTES     = OUTPUT_BITS / 8;
  localparam int BYTE_BITS = $clog2(BYTES);
  localparam int TW        = (PPS_TIMEOUT > 1) ? $clog2(PPS_TIMEOUT) : 1;

  localparam logic [TW-1:0]       TO_LAST  = (PPS_TIMEOUT > 0) ? TW'(PPS_TIMEOUT - 1) : '0;
  localparam logic [ADR_BITS-1:0] STAT_ADR = ADR_BITS'(NUM_CH << BYTE_BITS);
  localparam logic [ADR_BITS-1:0] BYTE_MSK = ADR_BITS'(BYTES - 1);
  localparam logic [CW-1:0]       CNT_MAX  = '1;

  logic [NUM_CH-1:0]      r_scal_q;
  logic [NUM_CH-1:0]      w_ev;
  logic [NUM_CH-1:0]      r_sat;
  logic [NUM_CH-1:0]      w_sat_nxt;
  logic [CW-1:0]          r_cnt     [NUM_CH];
  logic [CW-1:0]          w_cnt_inc [NUM_CH];
  logic [OUTPUT_BITS-1:0] r_latch   [NUM_CH];
  logic [TW-1:0]          r_per;
  logic                   w_hit;
  logic                   w_pe;
  logic                   r_upd;
  logic                   r_tmo;

  logic [OUTPUT_BITS-1:0] r_hold;
  logic [ADR_BITS-1:0]    r_tag;
  logic                   r_tag_vld;
  logic [7:0]             r_dat;
  logic                   r_vld;

  logic [ADR_BITS-1:0]    w_ch;
  logic [ADR_BITS-1:0]    w_byte;
  logic                   w_is_ch;
  logic                   w_use_hold;
  logic [OUTPUT_BITS-1:0] w_live_val;
  logic [OUTPUT_BITS-1:0] w_src_val;
  logic [OUTPUT_BITS-1:0] w_shift;
  logic [7:0]             w_rd_byte;

  assign w_ev  = (EDGE_MODE != 0) ? (bus.scal_i & ~r_scal_q) : bus.scal_i;
  assign w_hit = (PPS_TIMEOUT > 0) && (r_per == TO_LAST);
  assign w_pe  = bus.pps_i | w_hit;

  // The pe-cycle event is folded in here so the closing period owns it.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_cnt_inc[c] = r_cnt[c];
      if (w_ev[c] && (r_cnt[c] != CNT_MAX)) begin
        w_cnt_inc[c] = r_cnt[c] + CW'(1);
      end
      w_sat_nxt[c] = (w_cnt_inc[c] == CNT_MAX);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scal_q <= '0;
      r_sat    <= '0;
      r_per    <= '0;
      r_upd    <= 1'b0;
      r_tmo    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]   <= '0;
        r_latch[c] <= '0;
      end
    end else begin
      r_scal_q <= bus.scal_i;
      r_upd    <= w_pe;
      if (w_pe) begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_latch[c] <= w_cnt_inc[c][CW-1:PRESCALE_BITS];
          r_cnt[c]   <= '0;
        end
        r_sat <= w_sat_nxt;
        r_per <= '0;
        r_tmo <= ~bus.pps_i;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          r_cnt[c] <= w_cnt_inc[c];
        end
        if (PPS_TIMEOUT > 0) begin
          r_per <= r_per + TW'(1);
        end
      end
    end
  end

  always_comb begin
    w_ch       = bus.adr_i >> BYTE_BITS;
    w_byte     = bus.adr_i & BYTE_MSK;
    w_is_ch    = (w_ch < ADR_BITS'(NUM_CH));
    w_live_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch == ADR_BITS'(c)) begin
        w_live_val = r_latch[c];
      end
    end
    // Upper bytes of the channel last opened by a byte-0 read come from the snapshot.
    w_use_hold = r_tag_vld && (r_tag == w_ch) && (w_byte != '0);
    w_src_val  = w_use_hold ? r_hold : w_live_val;
    w_shift    = w_src_val >> {w_byte, 3'b000};
    w_rd_byte  = 8'h00;
    if (w_is_ch) begin
      w_rd_byte = w_shift[7:0];
    end else if (bus.adr_i == STAT_ADR) begin
      w_rd_byte = {6'b000000, |r_sat, r_tmo};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dat     <= 8'h00;
      r_vld     <= 1'b0;
      r_hold    <= '0;
      r_tag     <= '0;
      r_tag_vld <= 1'b0;
    end else begin
      r_vld <= bus.rd_i;
      r_dat <= bus.rd_i ? w_rd_byte : 8'h00;
      if (bus.rd_i && w_is_ch && (w_byte == '0)) begin
        r_hold    <= w_live_val;
        r_tag     <= w_ch;
        r_tag_vld <= 1'b1;
      end
    end
  end

  assign bus.dat_o     = r_dat;
  assign bus.valid_o   = r_vld;
  assign bus.update_o  = r_upd;
  assign bus.timeout_o = r_tmo;
endmodule
